// File: rtl/al4s3b_wb_pkg.sv
// Shared definitions for the AL4S3B fabric-side Wishbone register bus.
package al4s3b_wb_pkg;

    localparam int WB_ADR_WIDTH = 17;
    localparam int WB_DAT_WIDTH = 32;

    localparam logic [31:0] WB_DEFAULT_READ_VALUE = 32'hBAD_FAB_AC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/al4s3b_wb_initiator_if.sv
// AL4S3B register bus signal bundle; names follow the fabric-side WBs_* convention.
interface al4s3b_wb_if
    import al4s3b_wb_pkg::*;
#(
    parameter int ADR_WIDTH = WB_ADR_WIDTH,
    parameter int DAT_WIDTH = WB_DAT_WIDTH
);
    logic [ADR_WIDTH-1:0] WBs_ADR_o;
    logic                 WBs_CYC_o;
    logic                 WBs_STB_o;
    logic                 WBs_WE_o;
    logic                 WBs_RD_o;
    logic [3:0]           WBs_BYTE_STB_o;
    logic [DAT_WIDTH-1:0] WBs_DAT_o;
    logic [DAT_WIDTH-1:0] WBs_DAT_i;
    logic                 WBs_ACK_i;

    modport master (
        output WBs_ADR_o, WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o,
               WBs_BYTE_STB_o, WBs_DAT_o,
        input  WBs_DAT_i, WBs_ACK_i
    );

    modport slave (
        input  WBs_ADR_o, WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o,
               WBs_BYTE_STB_o, WBs_DAT_o,
        output WBs_DAT_i, WBs_ACK_i
    );
endinterface

// File: rtl/al4s3b_wb_timeout_cntr.sv
// Saturating bus-cycle counter; expired flags the last permitted cycle without ACK.
module al4s3b_wb_timeout_cntr #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            cnt_reg <= '0;
        end else if (enable && cnt_reg != SAT) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign expired = enable && (cnt_reg == LAST);
endmodule

// File: rtl/al4s3b_wb_initiator.sv
// Single-outstanding Wishbone initiator: command stream in, one bus cycle, response stream out.
module al4s3b_wb_initiator
    import al4s3b_wb_pkg::*;
#(
    parameter int                   ADR_WIDTH          = WB_ADR_WIDTH,
    parameter int                   DAT_WIDTH          = WB_DAT_WIDTH,
    parameter int                   TIMEOUT_CYCLES     = 15,
    parameter logic [DAT_WIDTH-1:0] DEFAULT_READ_VALUE = WB_DEFAULT_READ_VALUE
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADR_WIDTH-1:0] cmd_adr_i,
    input  logic [3:0]           cmd_byte_stb_i,
    input  logic [DAT_WIDTH-1:0] cmd_dat_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DAT_WIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    al4s3b_wb_if.master          wb
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUS  = BUS;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0]           state_reg;
    logic                 cyc_reg;
    logic                 we_reg;
    logic                 rd_reg;
    logic [ADR_WIDTH-1:0] adr_reg;
    logic [3:0]           byte_stb_reg;
    logic [DAT_WIDTH-1:0] wdat_reg;
    logic                 rsp_valid_reg;
    logic                 rsp_err_reg;
    logic [DAT_WIDTH-1:0] rsp_dat_reg;
    logic                 expired;

    al4s3b_wb_timeout_cntr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (WBs_CLK_i),
        .srst    (WBs_RST_i),
        .clear   (state_reg == S_IDLE),
        .enable  (state_reg == S_BUS),
        .expired (expired)
    );

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            state_reg     <= S_IDLE;
            cyc_reg       <= 1'b0;
            we_reg        <= 1'b0;
            rd_reg        <= 1'b0;
            adr_reg       <= '0;
            byte_stb_reg  <= '0;
            wdat_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_dat_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        cyc_reg      <= 1'b1;
                        we_reg       <= cmd_we_i;
                        rd_reg       <= ~cmd_we_i;
                        adr_reg      <= cmd_adr_i;
                        byte_stb_reg <= cmd_byte_stb_i;
                        wdat_reg     <= cmd_dat_i;
                        state_reg    <= S_BUS;
                    end
                end
                S_BUS: begin
                    // ACK is checked first so a late ACK on the expiry edge still completes cleanly.
                    if (wb.WBs_ACK_i || expired) begin
                        cyc_reg       <= 1'b0;
                        we_reg        <= 1'b0;
                        rd_reg        <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                        if (wb.WBs_ACK_i) begin
                            rsp_err_reg <= 1'b0;
                            rsp_dat_reg <= we_reg ? '0 : wb.WBs_DAT_i;
                        end else begin
                            rsp_err_reg <= 1'b1;
                            rsp_dat_reg <= DEFAULT_READ_VALUE;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o       = (state_reg == S_IDLE);
    assign rsp_valid_o       = rsp_valid_reg;
    assign rsp_err_o         = rsp_err_reg;
    assign rsp_dat_o         = rsp_dat_reg;
    assign wb.WBs_ADR_o      = adr_reg;
    assign wb.WBs_CYC_o      = cyc_reg;
    assign wb.WBs_STB_o      = cyc_reg;
    assign wb.WBs_WE_o       = we_reg;
    assign wb.WBs_RD_o       = rd_reg;
    assign wb.WBs_BYTE_STB_o = byte_stb_reg;
    assign wb.WBs_DAT_o      = wdat_reg;
endmodule

// File: tb/tb_al4s3b_wb_initiator.sv
// Directed bench for al4s3b_wb_initiator: writes, reads, timeout, backpressure, mid-cycle reset.
module tb_al4s3b_wb_initiator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [16:0] cmd_adr = '0;
    logic [3:0]  cmd_byte_stb = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc_cycles;

    al4s3b_wb_if #(.ADR_WIDTH(17), .DAT_WIDTH(32)) wb ();

    al4s3b_wb_initiator #(
        .ADR_WIDTH(17),
        .DAT_WIDTH(32),
        .TIMEOUT_CYCLES(15),
        .DEFAULT_READ_VALUE(32'hBAD_FAB_AC)
    ) dut (
        .WBs_CLK_i      (clk),
        .WBs_RST_i      (rst),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_we_i       (cmd_we),
        .cmd_adr_i      (cmd_adr),
        .cmd_byte_stb_i (cmd_byte_stb),
        .cmd_dat_i      (cmd_dat),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_dat_o      (rsp_dat),
        .rsp_err_o      (rsp_err),
        .wb             (wb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic we, input logic [16:0] adr, input logic [3:0] bs,
                        input logic [31:0] dat);
        cmd_valid    = 1'b1;
        cmd_we       = we;
        cmd_adr      = adr;
        cmd_byte_stb = bs;
        cmd_dat      = dat;
    endtask

    initial begin
        wb.WBs_ACK_i = 1'b0;
        wb.WBs_DAT_i = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_cyc", 32'(wb.WBs_CYC_o), 32'd0);
        chk("rst_stb", 32'(wb.WBs_STB_o), 32'd0);
        chk("rst_we", 32'(wb.WBs_WE_o), 32'd0);
        chk("rst_rd", 32'(wb.WBs_RD_o), 32'd0);
        chk("rst_adr", 32'(wb.WBs_ADR_o), 32'd0);
        chk("rst_bstb", 32'(wb.WBs_BYTE_STB_o), 32'd0);
        chk("rst_dato", wb.WBs_DAT_o, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        rst = 1'b0;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write, ACK in 2nd bus cycle
        send(1'b1, 17'h0000C, 4'hF, 32'h0000_00A5);
        tick();
        cmd_valid = 1'b0;
        chk("wr_cyc1", 32'(wb.WBs_CYC_o), 32'd1);
        chk("wr_stb1", 32'(wb.WBs_STB_o), 32'd1);
        chk("wr_we", 32'(wb.WBs_WE_o), 32'd1);
        chk("wr_rd", 32'(wb.WBs_RD_o), 32'd0);
        chk("wr_adr", 32'(wb.WBs_ADR_o), 32'h0000C);
        chk("wr_dato", wb.WBs_DAT_o, 32'h0000_00A5);
        chk("wr_bstb", 32'(wb.WBs_BYTE_STB_o), 32'hF);
        chk("wr_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("wr_cyc2", 32'(wb.WBs_CYC_o), 32'd1);
        chk("wr_no_rsp_yet", 32'(rsp_valid), 32'd0);
        wb.WBs_ACK_i = 1'b1;
        wb.WBs_DAT_i = 32'hDEAD_BEEF;
        tick();
        wb.WBs_ACK_i = 1'b0;
        chk("wr_cyc_end", 32'(wb.WBs_CYC_o), 32'd0);
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_dat", rsp_dat, 32'd0);
        chk("wr_rsp_err", 32'(rsp_err), 32'd0);
        $display("txn 1: write adr=0000c dat=000000a5 -> rsp_dat=%h err=%0d", rsp_dat, rsp_err);
        tick();
        chk("wr_rsp_done", 32'(rsp_valid), 32'd0);
        chk("wr_back_idle", 32'(cmd_ready), 32'd1);

        // Read, ACK in 1st bus cycle
        send(1'b0, 17'h00000, 4'hF, 32'h0);
        tick();
        cmd_valid = 1'b0;
        chk("rd_rd", 32'(wb.WBs_RD_o), 32'd1);
        chk("rd_we", 32'(wb.WBs_WE_o), 32'd0);
        chk("rd_rsp_early", 32'(rsp_valid), 32'd0);
        wb.WBs_ACK_i = 1'b1;
        wb.WBs_DAT_i = 32'h1234_5678;
        tick();
        wb.WBs_ACK_i = 1'b0;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_dat", rsp_dat, 32'h1234_5678);
        chk("rd_rsp_err", 32'(rsp_err), 32'd0);
        chk("rd_rd_end", 32'(wb.WBs_RD_o), 32'd0);
        $display("txn 2: read adr=00000 -> rsp_dat=%h err=%0d", rsp_dat, rsp_err);
        tick();

        // Read with no ACK: timeout
        send(1'b0, 17'h1FFF0, 4'hF, 32'h0);
        tick();
        cmd_valid = 1'b0;
        cyc_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!wb.WBs_CYC_o) break;
            cyc_cycles++;
            tick();
        end
        chk("to_cyc_cycles", 32'(cyc_cycles), 32'd15);
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_dat", rsp_dat, 32'hBAD_FAB_AC);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        $display("txn 3: read adr=1fff0 (no ack) -> rsp_dat=%h err=%0d cyc=%0d", rsp_dat, rsp_err,
                 cyc_cycles);
        tick();

        // ACK on the expiry edge
        send(1'b0, 17'h00040, 4'hF, 32'h0);
        tick();
        cmd_valid = 1'b0;
        repeat (14) tick();
        chk("ae_cyc_still", 32'(wb.WBs_CYC_o), 32'd1);
        wb.WBs_ACK_i = 1'b1;
        wb.WBs_DAT_i = 32'hCAFE_0001;
        tick();
        wb.WBs_ACK_i = 1'b0;
        chk("ae_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ae_rsp_err", 32'(rsp_err), 32'd0);
        chk("ae_rsp_dat", rsp_dat, 32'hCAFE_0001);
        $display("txn 4: read adr=00040 (ack at expiry) -> rsp_dat=%h err=%0d", rsp_dat, rsp_err);
        tick();

        // Response backpressure with a second command waiting
        rsp_ready = 1'b0;
        send(1'b0, 17'h00010, 4'hF, 32'h0);
        tick();
        cmd_valid = 1'b0;
        wb.WBs_ACK_i = 1'b1;
        wb.WBs_DAT_i = 32'h0000_5A5A;
        tick();
        wb.WBs_ACK_i = 1'b0;
        wb.WBs_DAT_i = 32'hFFFF_FFFF;
        send(1'b1, 17'h00020, 4'h3, 32'h0000_0055);
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_dat", rsp_dat, 32'h0000_5A5A);
            chk("bp_cyc", 32'(wb.WBs_CYC_o), 32'd0);
            tick();
        end
        $display("txn 5: read adr=00010 (held) -> rsp_dat=%h err=%0d", rsp_dat, rsp_err);
        rsp_ready = 1'b1;
        tick();
        chk("bp_rsp_released", 32'(rsp_valid), 32'd0);
        chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
        chk("bp_not_yet", 32'(wb.WBs_CYC_o), 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("bp2_cyc", 32'(wb.WBs_CYC_o), 32'd1);
        chk("bp2_adr", 32'(wb.WBs_ADR_o), 32'h00020);
        chk("bp2_bstb", 32'(wb.WBs_BYTE_STB_o), 32'h3);
        chk("bp2_we", 32'(wb.WBs_WE_o), 32'd1);
        wb.WBs_ACK_i = 1'b1;
        tick();
        wb.WBs_ACK_i = 1'b0;
        chk("bp2_rsp_dat", rsp_dat, 32'd0);
        chk("bp2_rsp_valid", 32'(rsp_valid), 32'd1);
        $display("txn 6: write adr=00020 dat=00000055 -> rsp_dat=%h err=%0d", rsp_dat, rsp_err);
        tick();

        // Reset during BUS, then a stray ACK
        send(1'b0, 17'h00100, 4'hF, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mr_in_bus", 32'(wb.WBs_CYC_o), 32'd1);
        rst = 1'b1;
        tick();
        chk("mr_cyc", 32'(wb.WBs_CYC_o), 32'd0);
        chk("mr_stb", 32'(wb.WBs_STB_o), 32'd0);
        chk("mr_rd", 32'(wb.WBs_RD_o), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        wb.WBs_ACK_i = 1'b1;
        wb.WBs_DAT_i = 32'h7777_7777;
        tick();
        wb.WBs_ACK_i = 1'b0;
        chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stray_cyc", 32'(wb.WBs_CYC_o), 32'd0);
        chk("stray_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("stray_rsp_dat", rsp_dat, 32'd0);
        $display("txn 7: read adr=00100 dropped by reset, stray ack ignored");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/al4s3b_wb_initiator.md
# al4s3b_wb_initiator

Single-outstanding Wishbone initiator that drives the AL4S3B FPGA-side register bus (WBs_ADR/CYC/STB/WE/RD/BYTE_STB/WR_DAT, ACK/RD_DAT). It converts a valid/ready command stream into one bus cycle at a time and returns a response stream carrying read data or an error.
- Intended uses: fabric-resident sequencers, self-test engines and testbench drivers exercising the FPGA register map and the QL reserved block.
- It includes a bus timeout, so a missing ACK cannot hang the fabric.

## Interface
Parameters:
- ADR_WIDTH, 17, byte-address width of WBs_ADR_o.
- DAT_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 15, bus cycles without ACK before the initiator aborts (≥1).
- DEFAULT_READ_VALUE, 32'hBAD_FAB_AC, returned on rsp_dat_o when a cycle times out.

Ports:
- WBs_CLK_i  in  1  bus clock; all logic on rising edge.
- WBs_RST_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  initiator can accept a command.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADR_WIDTH  byte address, passed through unmodified.
- cmd_byte_stb_i  in  4  byte enables.
- cmd_dat_i  in  DAT_WIDTH  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_dat_o  out  DAT_WIDTH  read data; 0 for writes; DEFAULT_READ_VALUE on timeout.
- rsp_err_o  out  1  1 = cycle timed out.
- WBs_ADR_o  out  ADR_WIDTH  bus address.
- WBs_CYC_o  out  1  cycle.
- WBs_STB_o  out  1  strobe.
- WBs_WE_o  out  1  write enable.
- WBs_RD_o  out  1  read enable; equals CYC & ~WE.
- WBs_BYTE_STB_o  out  4  byte strobes.
- WBs_DAT_o  out  DAT_WIDTH  write data.
- WBs_DAT_i  in  DAT_WIDTH  read data from target.
- WBs_ACK_i  in  1  target acknowledge.

## Operation
- **IDLE**
  - cmd_ready_o=1.
  - On cmd_valid_i & cmd_ready_o: latch we/adr/byte_stb/dat, clear the timeout counter, go to BUS.
- **BUS**
  - CYC=STB=1; WE, RD, ADR, BYTE_STB and DAT_o are driven from the latched values and stay stable for the whole cycle.
  - If WBs_ACK_i=1: capture WBs_DAT_i (reads) or 0 (writes), set err=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: data=DEFAULT_READ_VALUE, err=1, go to RESP.
  - Otherwise: increment the counter.
  - ACK and timeout in the same cycle: ACK wins, err=0.
- **RESP**
  - rsp_valid_o=1; rsp_dat_o and rsp_err_o stay stable until rsp_ready_i=1, then go to IDLE.
  - The consumer may hold rsp_ready_i high permanently.
- WBs_ACK_i outside BUS is ignored and leaves no state.
- Commands are never accepted while in BUS or RESP, so there is never more than one outstanding cycle.
- Counter width is $clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.
- Reset, in any state, including mid-cycle:
  - next edge goes to IDLE; the in-flight command is dropped with no response.
  - reset values: CYC/STB/WE/RD/rsp_valid/rsp_err = 0; ADR, BYTE_STB, WBs_DAT_o and rsp_dat_o = 0; cmd_ready_o=1 in the first cycle after reset deasserts.

## Timing
- All outputs are registered except cmd_ready_o, which is decoded from the state register.
- Command accepted at edge N: CYC/STB high from N through the edge where ACK is sampled.
- ACK sampled at edge M: CYC/STB low and rsp_valid_o high after edge M.
- Minimum latency is 2 cycles, from command handshake to rsp_valid_o, with ACK in the first bus cycle.
- Timeout: with no ACK, CYC is high for exactly TIMEOUT_CYCLES cycles, then rsp_valid_o rises with err=1.
- Back-to-back throughput is at least 3 cycles per transaction. RESP→IDLE costs one cycle; there is no bypass.
- ACK is a single-cycle pulse from the target. A target holding ACK for several cycles gets exactly one completion.

## Structure
- Package al4s3b_wb_pkg:
  - state enum {IDLE, BUS, RESP}.
  - DEFAULT_READ_VALUE.
  - WB address and data width constants, shared with the register blocks.
- Sub-module al4s3b_wb_timeout_cntr:
  - inputs: clear, enable.
  - output: expired.
  - parameter: TIMEOUT_CYCLES.
  - reused by other initiators.
- FSM and datapath latches live in the top module.

## Test plan
- Write adr=17'h0000C, dat=32'h0000_00A5, stb=4'hF, target ACKs in its 2nd bus cycle.
  - Bus: WE=1, RD=0, CYC high 2 cycles.
  - Response: rsp_dat=0, err=0.
- Read adr=17'h00000, target returns 32'h1234_5678 with ACK in its 1st bus cycle.
  - Bus: RD=1.
  - Response: rsp_dat=32'h1234_5678, err=0, rsp_valid 2 cycles after accept.
- Read to an unmapped address, no ACK, TIMEOUT_CYCLES=15.
  - CYC high exactly 15 cycles, then rsp_dat=32'hBAD_FAB_AC, err=1.
- ACK on the same edge the counter expires → err=0 and target data is returned.
- Hold rsp_ready_i=0 for 5 cycles while presenting a second command.
  - cmd_ready_o stays 0 and the response is held stable.
  - The second command is accepted 1 cycle after the response handshake.
- Assert WBs_RST_i during BUS.
  - CYC/STB are 0 after the next edge, no rsp_valid, cmd_ready_o=1 after release.
  - A stray ACK arriving later is ignored.
